// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
// Accepts one byte-addressed load/store at a time and drives a word-wide
// memory with a registered (1-cycle) read and word-only writes. Sub-word
// loads are extracted and extended; sub-word stores use read-modify-write.
// Little-endian byte numbering within a word.
//
// Handshake: req is sampled only while the FSM is IDLE (busy=0). A request
// seen while busy=1 is dropped, not queued. Completion is a one-cycle done
// pulse; err is meaningful only in that cycle. rdata holds the most recent
// successful load result until the next successful load replaces it.
module load_store_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [1:0]            mem_size,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;     // only the low half feeds SB/SH merges
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  // Misaligned accesses and encodings with no meaning for the access kind.
  function automatic logic bad_access(input logic st, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;          // LB / SB
      3'b001:  bad = a[0];          // LH / SH
      3'b010:  bad = |a;            // LW / SW
      3'b100:  bad = st;            // LBU, no store form
      3'b101:  bad = st | a[0];     // LHU, no store form
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane selection, extension and sub-word merge from the returned memory word.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_val = mem_rdata;
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (!funct3_q[0]) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and register-update decode.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata[15:0];
          if (bad_access(is_store, funct3, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (is_store && funct3 == 3'b010) begin
            err_d       = 1'b0;
            mem_wdata_d = wdata;
            state_d     = S_WRITE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (is_store_q) begin
          mem_wdata_d = merged;
          state_d     = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 16'd0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  // All memory-side controls decode from registered state only.
  assign mem_we    = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q && (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
  assign mem_size  = funct3_q[1:0];
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a registered-read
// word memory model; expected completions and writes go into queues that a
// negedge monitor drains.
module tb_load_store_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          is_store;
  logic [2:0]    funct3;
  logic [AW+1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done;
  logic          err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [2:0]    dbg_state;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: registered read, word write
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Scoreboard
  logic [32:0]      exp_q[$];     // {err, rdata}
  int               exp_cyc_q[$]; // cycle in which done must be seen
  logic [AW+31:0]   wr_q[$];      // {mem_addr, mem_wdata}
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations when the DUT completes or writes
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          logic [32:0] e;
          int          c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("rdata", 64'(rdata), 64'(e[31:0]));
          check("err", 64'(err), 64'(e[32]));
          check("done_cycle", 64'(cyc), 64'(c));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
        end else begin
          logic [AW+31:0] w;
          w = wr_q.pop_front();
          check("write_addr", 64'(mem_addr), 64'(w[AW+31:32]));
          check("write_data", 64'(mem_wdata), 64'(w[31:0]));
        end
      end
    end
  end

  // Driver helpers (called at a negedge, return at a negedge in IDLE)
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [AW+1:0] a,
                       input logic [31:0] wd, input int lat, input logic e_err,
                       input logic [31:0] e_rd, input logic do_wr, input logic [31:0] wr_word);
    is_store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
    exp_q.push_back({e_err, e_rd});
    exp_cyc_q.push_back(cyc + lat);
    if (do_wr) wr_q.push_back({a[AW+1:2], wr_word});
    @(negedge clk);
    req = 1'b0;
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //     st  f3      addr     wdata         lat err rdata expected   wr  word
    issue(1, 3'b010, 10'h010, 32'hDEADBEEF, 2, 0, 32'h00000000, 1, 32'hDEADBEEF); // SW
    issue(0, 3'b010, 10'h010, 32'h0,        3, 0, 32'hDEADBEEF, 0, 32'h0);        // LW
    issue(0, 3'b000, 10'h013, 32'h0,        3, 0, 32'hFFFFFFDE, 0, 32'h0);        // LB
    issue(0, 3'b100, 10'h013, 32'h0,        3, 0, 32'h000000DE, 0, 32'h0);        // LBU
    issue(0, 3'b001, 10'h012, 32'h0,        3, 0, 32'hFFFFDEAD, 0, 32'h0);        // LH
    issue(1, 3'b000, 10'h011, 32'h00000055, 4, 0, 32'hFFFFDEAD, 1, 32'hDEAD55EF); // SB
    issue(0, 3'b010, 10'h010, 32'h0,        3, 0, 32'hDEAD55EF, 0, 32'h0);        // LW
    issue(1, 3'b001, 10'h012, 32'h00001234, 4, 0, 32'hDEAD55EF, 1, 32'h123455EF); // SH
    issue(0, 3'b010, 10'h010, 32'h0,        3, 0, 32'h123455EF, 0, 32'h0);        // LW
    issue(0, 3'b101, 10'h010, 32'h0,        3, 0, 32'h000055EF, 0, 32'h0);        // LHU
    issue(0, 3'b000, 10'h010, 32'h0,        3, 0, 32'hFFFFFFEF, 0, 32'h0);        // LB
    issue(0, 3'b010, 10'h011, 32'h0,        1, 1, 32'hFFFFFFEF, 0, 32'h0);        // misaligned LW
    issue(1, 3'b001, 10'h013, 32'h0000FFFF, 1, 1, 32'hFFFFFFEF, 0, 32'h0);        // misaligned SH
    issue(0, 3'b011, 10'h010, 32'h0,        1, 1, 32'hFFFFFFEF, 0, 32'h0);        // illegal load
    issue(1, 3'b100, 10'h010, 32'h0,        1, 1, 32'hFFFFFFEF, 0, 32'h0);        // illegal store
    issue(1, 3'b010, 10'h3FC, 32'h80706050, 2, 0, 32'hFFFFFFEF, 1, 32'h80706050); // SW top word
    issue(0, 3'b000, 10'h3FF, 32'h0,        3, 0, 32'hFFFFFF80, 0, 32'h0);        // LB top byte
    issue(0, 3'b101, 10'h3FE, 32'h0,        3, 0, 32'h00008070, 0, 32'h0);        // LHU top half
    issue(0, 3'b001, 10'h3FE, 32'h0,        3, 0, 32'hFFFF8070, 0, 32'h0);        // LH top half
    issue(1, 3'b010, 10'h014, 32'hCAFEF00D, 2, 0, 32'hFFFF8070, 1, 32'hCAFEF00D); // SW word 5

    // req held high with changing fields: only the first and the one
    // present in the IDLE cycle after done are executed.
    begin
      int c0;
      c0 = cyc;
      is_store = 0; funct3 = 3'b010; addr = 10'h010; wdata = 32'h0; req = 1'b1;
      exp_q.push_back({1'b0, 32'h123455EF}); exp_cyc_q.push_back(c0 + 3);
      exp_q.push_back({1'b0, 32'hCAFEF00D}); exp_cyc_q.push_back(c0 + 7);
      @(negedge clk); is_store = 1; funct3 = 3'b010; addr = 10'h020; wdata = 32'h1;
      @(negedge clk); is_store = 1; funct3 = 3'b000; addr = 10'h021; wdata = 32'h2;
      @(negedge clk); is_store = 0; funct3 = 3'b000; addr = 10'h022;
      @(negedge clk); is_store = 0; funct3 = 3'b010; addr = 10'h014;
      @(negedge clk); req = 1'b0;
      wait_done();
    end

    // Reset while an SB waits on its read: abandoned, no write.
    is_store = 1; funct3 = 3'b000; addr = 10'h014; wdata = 32'h000000AA; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("pre_reset_state", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_mem_we", 64'(mem_we), 64'h0);
    check("abort_rdata", 64'(rdata), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 3'b010, 10'h014, 32'h0, 3, 0, 32'hCAFEF00D, 0, 32'h0);               // word intact

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations actual=%0d/%0d required=0/0", exp_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: the core's load/store unit.
- Accepts one byte-addressed load/store request at a time from the execute stage.
- Drives the word-addressed, word-wide data memory, which has a registered read (1-cycle latency) and word-only writes.
- Handles byte/halfword extraction, sign/zero extension, and read-modify-write for sub-word stores.
- Little-endian.

Parameters:
- ADDR_WIDTH, 8, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, data word width; fixed at 32 for this block.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- addr  input  ADDR_WIDTH+2  byte address.
- wdata  input  32  store data; low byte/halfword used for SB/SH.
- rdata  output  32  load result, extended; held until next load completes.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = misaligned access or illegal funct3.
- busy  output  1  high whenever state != IDLE.
- mem_addr  output  ADDR_WIDTH  word address, equal to addr_q[ADDR_WIDTH+1:2].
- mem_we  output  1  memory write enable.
- mem_size  output  2  funct3_q[1:0], informational.
- mem_wdata  output  32  word written to memory.
- mem_rdata  input  32  memory read data, valid the cycle after address is presented.

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE; rdata=0, done=0, err=0, mem_we=0, mem_wdata=0, captured registers=0. Reset mid-operation abandons the access; no write occurs after the reset edge.
- mem_we, busy and mem_addr decode from registered state; no combinational path from req to mem_we.
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE.
- IDLE, req=1: capture is_store, funct3, addr, wdata.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 → DONE with err=1. No memory access.
  - SW → WRITE, with mem_wdata = wdata.
  - Any load, SB or SH → RD_ISSUE.
- RD_ISSUE: mem_addr valid; the memory samples it at the end of this cycle.
- RD_WAIT: mem_rdata valid.
  - Load: rdata <= selected lane. Byte lane = addr_q[1:0]; half lane = addr_q[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU. Next state DONE.
  - SB/SH: mem_wdata <= mem_rdata with the addressed byte/half replaced by wdata_q[7:0] / wdata_q[15:0]. Next state WRITE.
- WRITE: mem_we=1 for exactly one cycle → DONE.
- DONE: done=1 for one cycle (err as determined) → IDLE.
- A new req is accepted in the cycle after done.
- req while busy=1 is ignored, not queued.
- Latency from the req-sampling edge to done high:
  - LW/LB/LH: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - error: 1 cycle.
- rdata changes only on a successful load; stores and errors leave it unchanged.
- Highest address (all ones) is legal; no wrap handling is needed beyond the mem_addr truncation.

Test Plan:
- Reset, then SW addr=0x10, wdata=0xDEADBEEF → mem_we high exactly 1 cycle with mem_addr=4, mem_wdata=0xDEADBEEF; done 2 cycles after req.
- LW addr=0x10 → done 3 cycles after req, rdata=0xDEADBEEF, err=0. Then LB addr=0x13 → rdata=0xFFFFFFDE; LBU addr=0x13 → rdata=0x000000DE; LH addr=0x12 → rdata=0xFFFFDEAD.
- SB addr=0x11, wdata=0x55 over word 0xDEADBEEF → exactly one write, mem_wdata=0xDEAD55EF; done 4 cycles after req; a following LW returns 0xDEAD55EF. SH addr=0x12, wdata=0x1234 → 0x123455EF.
- Misaligned LW addr=0x11, SH addr=0x13, and funct3=011 load → done+err=1 one cycle after req; mem_we never asserted; rdata unchanged.
- req held high continuously with changing fields during a LW → only the first request is executed; the second is accepted in the cycle after done.
- rst_n=0 asserted in RD_WAIT of an SB → next cycle IDLE, busy=0, done=0; mem_we never asserted; memory word unchanged.
